// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults and the 8-bit output clamp limits.
package cnn_pkg;
  localparam int LANES_D = 40;
  localparam int ACC_W_D = 32;
  localparam int CH_D    = 64;
  localparam int MUL_W_D = 16;
  localparam int SH_W_D  = 5;
  localparam logic [7:0] OUT_MIN = 8'd0;
  localparam logic [7:0] OUT_MAX = 8'd255;
endpackage

// File: rtl/conv_rescale_if.sv
// Accumulator beat in / rescaled 8-bit beat out for one conv_rescale instance.
interface conv_rescale_if #(
  parameter int LANES = 40,
  parameter int ACC_W = 32,
  parameter int CH    = 64
) ();
  localparam int CH_W = $clog2(CH);
  logic                   valid_i;
  logic                   frame_start_i;
  logic [LANES*ACC_W-1:0] data_i;
  logic                   valid_o;
  logic [LANES*8-1:0]     data_o;
  logic [CH_W-1:0]        ch_o;

  modport master (output valid_i, frame_start_i, data_i, input valid_o, data_o, ch_o);
  modport slave  (input valid_i, frame_start_i, data_i, output valid_o, data_o, ch_o);
endinterface

// File: rtl/conv_rescale_lane.sv
// One lane: S2 product register, S3 round-half-up shift with ReLU/255 clamp.
module conv_rescale_lane import cnn_pkg::*; #(
  parameter int ACC_W = 32,
  parameter int MUL_W = 16,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_s2,
  input  logic             en_s3,
  input  logic [ACC_W-1:0] acc,
  input  logic [MUL_W-1:0] mul,
  input  logic [SH_W-1:0]  shift,
  output logic [7:0]       q
);
  localparam int P_W = ACC_W + MUL_W + 1;
  localparam int S_W = P_W + 1;

  logic signed [P_W-1:0] acc_x, mul_x, prod, prod_q;
  logic signed [S_W-1:0] rnd, sum, r;
  logic [7:0]            clamp;

  // Both operands widened to the full product width so the multiply is exact.
  assign acc_x = {{(P_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign mul_x = {{(P_W-MUL_W){1'b0}}, mul};
  assign prod  = acc_x * mul_x;

  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = S_W'(1) << (shift - SH_W'(1));
    sum = {prod_q[P_W-1], prod_q} + rnd;
    r   = sum >>> shift;
    if (r[S_W-1])          clamp = OUT_MIN;
    else if (|r[S_W-2:8])  clamp = OUT_MAX;
    else                   clamp = r[7:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod_q <= '0;
      q      <= '0;
    end else begin
      if (en_s2) prod_q <= prod;
      if (en_s3) q      <= clamp;
    end
endmodule

// File: rtl/conv_rescale.sv
// Per-channel requantizer: scale table, channel counter, S1 regs, valid pipe, lane array.
module conv_rescale import cnn_pkg::*; #(
  parameter  int LANES = LANES_D,
  parameter  int ACC_W = ACC_W_D,
  parameter  int CH    = CH_D,
  parameter  int MUL_W = MUL_W_D,
  parameter  int SH_W  = SH_W_D,
  localparam int CH_W  = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_addr,
  input  logic [MUL_W-1:0] cfg_mul,
  input  logic [SH_W-1:0]  cfg_shift,
  conv_rescale_if.slave    bus
);
  localparam int STAGES = 3;

  logic [MUL_W-1:0]              mul_tab [CH];
  logic [SH_W-1:0]               sh_tab  [CH];
  logic [CH_W-1:0]               ch_cnt, beat_ch, ch_nxt;
  logic [STAGES:1]               vld_q;
  logic [STAGES:0]               vld_pipe;
  logic [LANES-1:0][ACC_W-1:0]   s1_data;
  logic [MUL_W-1:0]              s1_mul;
  logic [SH_W-1:0]               s1_sh, s2_sh;
  logic [CH_W-1:0]               s1_ch, s2_ch;
  logic [LANES-1:0][7:0]         q;

  assign vld_pipe     = {vld_q, bus.valid_i};
  assign bus.valid_o  = vld_pipe[STAGES];
  assign bus.data_o   = q;

  assign beat_ch = bus.frame_start_i ? '0 : ch_cnt;
  assign ch_nxt  = (beat_ch == CH_W'(CH-1)) ? '0 : beat_ch + CH_W'(1);

  // The lookup below reads before this edge's write, so a same-cycle hit sees the old entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        mul_tab[i] <= MUL_W'(1);
        sh_tab[i]  <= '0;
      end
    end else if (cfg_we) begin
      mul_tab[cfg_addr] <= cfg_mul;
      sh_tab[cfg_addr]  <= cfg_shift;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q   <= '0;
      ch_cnt  <= '0;
      s1_data <= '0;
      s1_mul  <= '0;
      s1_sh   <= '0;
      s1_ch   <= '0;
      s2_sh   <= '0;
      s2_ch   <= '0;
      bus.ch_o <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (bus.valid_i) begin
        ch_cnt  <= ch_nxt;
        s1_data <= bus.data_i;
        s1_mul  <= mul_tab[beat_ch];
        s1_sh   <= sh_tab[beat_ch];
        s1_ch   <= beat_ch;
      end
      if (vld_pipe[1]) begin
        s2_sh <= s1_sh;
        s2_ch <= s1_ch;
      end
      if (vld_pipe[2]) bus.ch_o <= s2_ch;
    end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    conv_rescale_lane #(.ACC_W(ACC_W), .MUL_W(MUL_W), .SH_W(SH_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en_s2 (vld_pipe[1]),
      .en_s3 (vld_pipe[2]),
      .acc   (s1_data[k]),
      .mul   (s1_mul),
      .shift (s2_sh),
      .q     (q[k])
    );
  end
endmodule

// File: tb/tb_conv_rescale.sv
// Directed vector bench for conv_rescale: table of beats plus wrap/frame_start/reset sequences.
module tb_conv_rescale;
  localparam int LANES = 4;
  localparam int ACC_W = 32;
  localparam int CH    = 64;
  localparam int MUL_W = 16;
  localparam int SH_W  = 5;
  localparam int CH_W  = 6;

  typedef struct {
    int we; int addr; int mul; int sh;
    int v;  int fs;   int acc; int xd; int xc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [CH_W-1:0]  cfg_addr = '0;
  logic [MUL_W-1:0] cfg_mul = '0;
  logic [SH_W-1:0]  cfg_shift = '0;

  always #5 clk = ~clk;

  conv_rescale_if #(.LANES(LANES), .ACC_W(ACC_W), .CH(CH)) bus ();

  conv_rescale #(.LANES(LANES), .ACC_W(ACC_W), .CH(CH), .MUL_W(MUL_W), .SH_W(SH_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_mul   (cfg_mul),
    .cfg_shift (cfg_shift),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic       pv [3];
  logic [7:0] pd [3];
  logic [5:0] pc [3];
  logic [7:0] last_d;
  logic [5:0] last_c;
  vec_t tv [$];

  function automatic vec_t mk(int we, int addr, int mul, int sh, int v, int fs, int acc, int xd, int xc);
    vec_t t;
    t.we = we; t.addr = addr; t.mul = mul; t.sh = sh;
    t.v = v; t.fs = fs; t.acc = acc; t.xd = xd; t.xc = xc;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [LANES*8-1:0] act, input logic [LANES*8-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; pc[i] = '0; end
    last_d = '0;
    last_c = '0;
  endtask

  // Outputs visible after an edge belong to the beat presented three edges earlier.
  task automatic tick(input int v, input int fs, input int acc, input int xd, input int xc);
    bus.valid_i       = (v != 0);
    bus.frame_start_i = (fs != 0);
    for (int k = 0; k < LANES; k++) bus.data_i[k*ACC_W +: ACC_W] = acc;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    for (int i = 2; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; pc[i] = pc[i-1]; end
    pv[0] = (v != 0); pd[0] = 8'(xd); pc[0] = 6'(xc);
    cmp("valid_o", {31'b0, bus.valid_o}, {31'b0, pv[2]});
    if (pv[2]) begin last_d = pd[2]; last_c = pc[2]; end
    cmp("data_o", bus.data_o, {LANES{last_d}});
    cmp("ch_o", {26'b0, bus.ch_o}, {26'b0, last_c});
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.frame_start_i = 1'b0;
    bus.data_i = '0;
    clear_model();

    // default table, rounding on entry 0, config collision on entry 5, saturation on entry 1
    tv.push_back(mk(0,0,0,0,       1,0, 200,   200,0));
    tv.push_back(mk(0,0,0,0,       1,0, 300,   255,1));
    tv.push_back(mk(0,0,0,0,       1,0, -5,    0,  2));
    tv.push_back(mk(1,0,3,2,       0,0, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       1,1, 5,     4,  0));
    tv.push_back(mk(0,0,0,0,       1,1, 6,     5,  0));
    tv.push_back(mk(0,0,0,0,       1,1, -6,    0,  0));
    tv.push_back(mk(0,0,0,0,       1,0, 7,     7,  1));
    tv.push_back(mk(0,0,0,0,       1,0, 1,     1,  2));
    tv.push_back(mk(0,0,0,0,       1,0, 1,     1,  3));
    tv.push_back(mk(0,0,0,0,       1,0, 1,     1,  4));
    tv.push_back(mk(1,5,2,0,       1,0, 10,    10, 5));
    tv.push_back(mk(0,0,0,0,       1,1, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       1,0, 2,     2,  1));
    tv.push_back(mk(0,0,0,0,       1,0, 2,     2,  2));
    tv.push_back(mk(0,0,0,0,       1,0, 2,     2,  3));
    tv.push_back(mk(0,0,0,0,       1,0, 2,     2,  4));
    tv.push_back(mk(0,0,0,0,       1,0, 10,    20, 5));
    tv.push_back(mk(1,1,65535,31,  0,0, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       1,1, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       1,0, 32'h80000000, 0, 1));
    tv.push_back(mk(0,0,0,0,       1,1, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       1,0, 32'h7FFFFFFF, 255, 1));
    tv.push_back(mk(0,0,0,0,       0,0, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       0,0, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       0,0, 0,     0,  0));
    tv.push_back(mk(0,0,0,0,       0,0, 0,     0,  0));

    repeat (2) @(posedge clk);
    #1;
    cmp("rst_valid_o", {31'b0, bus.valid_o}, '0);
    cmp("rst_data_o", bus.data_o, '0);
    cmp("rst_ch_o", {26'b0, bus.ch_o}, '0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      cfg_we    = (tv[i].we != 0);
      cfg_addr  = CH_W'(tv[i].addr);
      cfg_mul   = MUL_W'(tv[i].mul);
      cfg_shift = SH_W'(tv[i].sh);
      tick(tv[i].v, tv[i].fs, tv[i].acc, tv[i].xd, tv[i].xc);
    end

    // 65 beats from a frame start: channels 0..63 then wrap to 0
    for (int i = 0; i < 65; i++) tick(1, (i == 0) ? 1 : 0, 0, 0, i % CH);
    for (int c = 1; c <= 9; c++) tick(1, 0, 0, 0, c);
    tick(1, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 1);
    repeat (3) tick(0, 0, 0, 0, 0);

    // bubble pattern 1,0,1,1 then async reset drops the last beat
    tick(1, 0, 11, 11, 2);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 12, 12, 3);
    tick(1, 0, 13, 13, 4);
    tick(0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("mid_rst_valid_o", {31'b0, bus.valid_o}, '0);
    cmp("mid_rst_data_o", bus.data_o, '0);
    cmp("mid_rst_ch_o", {26'b0, bus.ch_o}, '0);
    clear_model();
    #2;
    rst_n = 1'b1;
    repeat (4) tick(0, 0, 0, 0, 0);
    tick(1, 0, 42, 42, 0);
    repeat (3) tick(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_rescale.md
# conv_rescale

Per-channel requantization stage between a convolution accumulator array and every consumer of rescaled 8-bit feature maps, including the per-layer result-test tap. Each `valid_i` beat carries one output channel of LANES signed accumulators. The block multiplies each lane by that channel's scale and applies a rounding right shift. It then applies ReLU and saturation to produce unsigned 8-bit values, tagged with the channel index.

## Interface
Parameters:
- LANES, 40, accumulator lanes per beat (pixels of one channel)
- ACC_W, 32, signed accumulator width
- CH, 64, output channels per frame; channel counter wraps at CH-1
- MUL_W, 16, unsigned per-channel multiplier width
- SH_W, 5, per-channel shift width (shift 0..31)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write strobe for scale table
- cfg_addr  in  $clog2(CH)  channel entry to write
- cfg_mul  in  MUL_W  multiplier written to entry
- cfg_shift  in  SH_W  shift written to entry
- frame_start_i  in  1  qualifies with valid_i; forces that beat to channel 0
- valid_i  in  1  input beat valid (no backpressure)
- data_i  in  LANES*ACC_W  lane k at bits [(k+1)*ACC_W-1 -: ACC_W]
- valid_o  out  1  output beat valid
- data_o  out  LANES*8  lane k at bits [(k+1)*8-1 -: 8]
- ch_o  out  $clog2(CH)  channel index of the current output beat

## Operation
- Scale table: CH entries of {mul, shift} in flops. Reset value of every entry is mul=1, shift=0. A cfg_we write updates the entry on that clock edge.
- Channel counter ch_cnt: resets to 0. Beat channel = 0 if frame_start_i, else ch_cnt. On valid_i, ch_cnt <= beat channel + 1, wrapping CH-1 -> 0. Without valid_i, ch_cnt holds and frame_start_i is ignored.
- Per lane:
  - Product p = acc (signed ACC_W) * {1'b0, mul}, width ACC_W+MUL_W+1, exact.
  - If shift > 0: r = (p + (1 << (shift-1))) >>> shift, an arithmetic shift with round-half-up. If shift = 0: r = p.
  - Output = 0 if r < 0; 255 if r > 255; otherwise r[7:0].
- No stall or backpressure. Every accepted beat emerges exactly once, in order.

## Timing
- Stage 1 (S1): register data_i, the table lookup {mul, shift} for the beat channel, the channel, and valid.
- Stage 2 (S2): register the products.
- Stage 3 (S3): register the round/shift/clamp result into data_o, ch_o and valid_o.
- Latency: beat with valid_i at edge t appears with valid_o high after edge t+3. Throughput is one beat per cycle.
- Valid bubbles propagate unchanged. When valid_o=0, data_o and ch_o hold their last values.
- Reset values: valid_o=0, data_o=0, ch_o=0, ch_cnt=0, all pipeline valids 0. Reset mid-stream discards all in-flight beats; no output follows until a new valid_i.
- Config/data collision: if cfg_we and valid_i occur in the same cycle for the same channel, the beat uses the OLD table value. Beats accepted on later cycles use the new value. A write never affects beats already in S1–S3.
- frame_start_i together with valid_i while ch_cnt≠0 truncates the previous frame: that beat is channel 0, and the next valid_i beat is channel 1.

## Structure
- Shared package cnn_pkg: LANES, ACC_W, CH, MUL_W, SH_W defaults and the 8-bit output clamp constants (0, 255). Layer instances override LANES/CH (e.g. conv2: LANES=1152, conv3: LANES=36, CH=32).
- Sub-module conv_rescale_lane: one lane's S2 product register and S3 round/clamp register, with mul/shift shared from the parent. The top level holds the table, channel counter, S1 registers and valid pipeline, and instantiates LANES lanes in a generate loop.

## Test plan
- Reset defaults:
  - Stimulus: after reset, valid_i with all lanes = 200, then 300, then -5.
  - Response: three consecutive valid_o beats, lanes = 200, 255 and 0; ch_o = 0, 1, 2; each appears 3 cycles after its input.
- Rounding:
  - Stimulus: entry 0 set to mul=3, shift=2; lanes = 5, 6 and -6.
  - Response: 15>>2 rounds to 4; 18 gives 5 (exactly half rounds up); -18 gives -4, clamped to 0.
- Channel wrap and frame_start:
  - Stimulus: 65 consecutive valid beats; then frame_start_i on the beat where ch_cnt=10.
  - Response: ch_o runs 0..63 then 0. The frame_start beat has ch_o=0 and the following beat has ch_o=1.
- Config collision:
  - Stimulus: cfg_we to entry 5 with mul=2, in the same cycle as the channel-5 beat; lanes = 10.
  - Response: that beat outputs 10. The next frame's channel-5 beat outputs 20.
- Bubbles and reset:
  - Stimulus: valid_i pattern 1,0,1,1; assert rst_n low one cycle after the last beat.
  - Response: valid_o pattern 1,0,1 visible, then the remaining beat is dropped; all outputs return to 0.
- Saturation extremes:
  - Stimulus: acc = 0x7FFFFFFF and 0x80000000, with mul=0xFFFF, shift=31.
  - Response: 255 and 0. The product is computed without overflow.
